// File: rtl/ps2_hex_formatter_pkg.sv
// Shared definitions for the PS/2 hex formatter: ASCII constants, FSM state
// encoding and the nibble-to-ASCII conversion.
package ps2_hex_formatter_pkg;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A_UC = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_SEP  = 3'd3,
    ST_LF   = 3'd4
  } fmt_state_e;

  // Uppercase hex digit for a 4-bit value.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = ASCII_ZERO + {4'd0, n};
    else           r = ASCII_A_UC + {4'd0, n} - 8'd10;
    return r;
  endfunction

endpackage

// File: rtl/ps2_hex_formatter_if.sv
// Byte-in / character-out signal bundle between the keyboard receiver,
// the formatter and the UART transmit FIFO.
interface ps2_hex_formatter_if;
  // Handshake: in_valid is a one-cycle strobe with no back-pressure toward the
  // keyboard; tx_full is the UART's back-pressure, and wr_en is a one-cycle
  // write strobe that is never raised in response to a cycle with tx_full=1.
  logic       in_valid;
  logic [7:0] in_data;
  logic       tx_full;
  logic       wr_en;
  logic [7:0] wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_full,
    output wr_en,
    output wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    output tx_full,
    input  wr_en,
    input  wr_data
  );
endinterface

// File: rtl/ps2_hex_formatter_byte_fifo.sv
// Synchronous FIFO with show-ahead output; a push while full is accepted only
// when a pop happens in the same cycle.
module ps2_hex_formatter_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ps2_hex_formatter.sv
// Turns received PS/2 bytes into "HH " text (CR LF every LINE_BYTES bytes)
// and paces the characters into a UART write port, at most one per two cycles.
module ps2_hex_formatter
  import ps2_hex_formatter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LINE_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_hex_formatter_if.slave    bus,
  output logic [7:0]            drop_cnt,
  output logic                  busy,
  output fmt_state_e            dbg_state
);

  localparam int CW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_BYTES - 1);

  fmt_state_e    state_q;
  logic [7:0]    cur_q;
  logic [CW-1:0] col_q;
  logic          gap_q;
  logic          wr_en_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    drop_cnt_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_dout;
  logic          drop;
  logic          can_emit;
  logic [7:0]    emit_char;

  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_push = bus.in_valid && (!fifo_full || fifo_pop);
  assign drop      = bus.in_valid && !fifo_push;

  ps2_hex_formatter_byte_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (bus.in_data),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // gap blocks the cycle right after a write so tx_full can catch up.
  assign can_emit = (state_q != ST_IDLE) && !bus.tx_full && !gap_q;

  always_comb begin
    emit_char = 8'h00;
    case (state_q)
      ST_HI:   emit_char = nibble_to_ascii(cur_q[7:4]);
      ST_LO:   emit_char = nibble_to_ascii(cur_q[3:0]);
      ST_SEP:  emit_char = (col_q == COL_LAST) ? ASCII_CR : ASCII_SP;
      ST_LF:   emit_char = ASCII_LF;
      default: emit_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= 8'h00;
      col_q      <= '0;
      gap_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      gap_q   <= 1'b0;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;

      if (state_q == ST_IDLE) begin
        if (!fifo_empty) begin
          cur_q   <= fifo_dout;
          state_q <= ST_HI;
        end
      end else if (can_emit) begin
        wr_en_q   <= 1'b1;
        wr_data_q <= emit_char;
        gap_q     <= 1'b1;
        case (state_q)
          ST_HI:   state_q <= ST_LO;
          ST_LO:   state_q <= ST_SEP;
          ST_SEP: begin
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= ST_LF;
            end else begin
              col_q   <= col_q + CW'(1);
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign drop_cnt    = drop_cnt_q;
  // Stays high through the cycle carrying the final write strobe.
  assign busy        = !fifo_empty || (state_q != ST_IDLE) || wr_en_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_hex_formatter.sv
// Bench for ps2_hex_formatter: directed timing cases plus randomized traffic,
// checked through an expected-character queue against a text-level model.
module tb_ps2_hex_formatter;
  import ps2_hex_formatter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int LINE_BYTES = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_hex_formatter_if bus();
  logic [7:0] drop_cnt;
  logic       busy;
  fmt_state_e dbg_state;

  ps2_hex_formatter #(
    .DEPTH      (DEPTH),
    .LINE_BYTES (LINE_BYTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         wr_cyc_q[$];
  int         model_col = 0;
  bit         rand_full_en = 1'b0;
  int         t0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  // Reference text for one accepted byte: two digits, then space or CR LF.
  task automatic model_push(input logic [7:0] b);
    exp_q.push_back(hex_char(int'(b) / 16));
    exp_q.push_back(hex_char(int'(b) % 16));
    if (model_col == LINE_BYTES - 1) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      model_col = 0;
    end else begin
      exp_q.push_back(8'h20);
      model_col++;
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_full = 1'b0;
  logic       prev_wr   = 1'b0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      wr_cyc_q.push_back(cyc);
      check("emit_rule", {30'd0, prev_full, prev_wr}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: actual=0x%0h required=none", bus.wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_data", bus.wr_data, mon_exp);
      end
    end
    prev_full = bus.tx_full;
    prev_wr   = bus.wr_en;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] d, input bit acc);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    if (v && acc) model_push(d);
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wait_idle: actual=busy/%0d pending required=idle within %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic send_one(input logic [7:0] b);
    drive(1'b1, b, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_idle(200);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    model_col = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_wr_times(input string name, input int base);
    check({name, "_count"}, wr_cyc_q.size(), 3);
    if (wr_cyc_q.size() == 3)
      for (int k = 0; k < 3; k++) check({name, "_cycle"}, wr_cyc_q[k] - base, base + 0 == base ? 3 + 2 * k : 0);
  endtask

  // Random UART back-pressure, only while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_full_en) bus.tx_full = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.tx_full  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_wr_data", bus.wr_data, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_busy", busy, 0);
    check("reset_state", dbg_state, ST_IDLE);

    // Single byte latency: writes at cycles 3/5/7, idle by cycle 8.
    wr_cyc_q.delete();
    drive(1'b1, 8'h1C, 1'b1);
    t0 = cyc;
    drive(1'b0, 8'h00, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("single_busy_c8", busy, 0);
    wait_idle(50);
    check_wr_times("single", t0);

    // Full line: eighth byte ends in CR LF, column restarts afterwards.
    do_reset();
    for (int i = 0; i <= 8; i++) send_one(8'(i));

    // Stall: tx_full high cycles 2..21, first write at cycle 23.
    do_reset();
    wr_cyc_q.delete();
    drive(1'b1, 8'h5A, 1'b1);
    t0 = cyc;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    bus.tx_full = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.tx_full = 1'b0;
    wait_idle(100);
    check("stall_count", wr_cyc_q.size(), 3);
    if (wr_cyc_q.size() == 3)
      for (int k = 0; k < 3; k++) check("stall_cycle", wr_cyc_q[k] - t0, 23 + 2 * k);

    // Overflow: six bytes against a stalled UART, the sixth is lost.
    do_reset();
    bus.tx_full = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i), i < 5);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("drop_one", drop_cnt, 1);
    bus.tx_full = 1'b0;
    wait_idle(200);

    // Drop counter saturation.
    do_reset();
    bus.tx_full = 1'b1;
    for (int i = 0; i < 300; i++) drive(1'b1, 8'(i), i < 5);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("drop_saturate", drop_cnt, 255);
    bus.tx_full = 1'b0;
    wait_idle(200);
    do_reset();
    @(negedge clk);
    check("drop_after_reset", drop_cnt, 0);

    // Reset during the LO digit abandons the triplet.
    drive(1'b1, 8'h77, 1'b1);
    t0 = cyc;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    model_col = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cycle", cyc - t0, 5);
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_wr_data", bus.wr_data, 0);
    check("midrst_busy", busy, 0);
    send_one(8'hAB);
    for (int i = 0; i < 8; i++) send_one(8'($urandom));

    // Digit boundary.
    do_reset();
    send_one(8'h9F);
    send_one(8'hA0);

    // Randomized bursts under random back-pressure; bursts fit the FIFO.
    do_reset();
    rand_full_en = 1'b1;
    for (int b = 0; b < 60; b++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      for (int j = 0; j < len; j++) begin
        drive(1'b1, 8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) drive(1'b0, 8'h00, 1'b0);
      end
      drive(1'b0, 8'h00, 1'b0);
      wait_idle(2000);
    end
    rand_full_en = 1'b0;
    @(posedge clk);
    #1;
    bus.tx_full = 1'b0;
    @(negedge clk);
    check("random_no_drops", drop_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
